led_string_multi: RTL and testbench

Parametrised multi-channel WS2812-class LED strip driver: the successor to the single-strip `led_string` FSM. It drives `CHANNELS` independent strips in lock-step, each `N_LEDS` long, with all bit timings set by cycle-count parameters. A start/busy/done handshake and an optional auto-repeat mode let the pattern generator upstream schedule frames. It sits between the colour-pattern logic and the FPGA pins that drive the strips.

---
 rtl/led_string_multi.sv | 129 ++++++++++++
 tb/tb_led_string_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_string_multi.sv
// led_string_multi: drives CHANNELS WS2812-class strips in lock-step from one shared bit timer.
// Define LED_BRIGHTNESS_EN to add a brightness input that scales every byte at pixel load.
module led_string_multi #(
   parameter int CHANNELS  = 2,
   parameter int N_LEDS    = 144,
   parameter int T0H_CYC   = 19,
   parameter int T1H_CYC   = 38,
   parameter int BIT_CYC   = 60,
   parameter int RESET_CYC = 3840
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CHANNELS*N_LEDS*24-1:0] colors,
   input  logic                          start,
   input  logic                          repeat_en,
`ifdef LED_BRIGHTNESS_EN
   input  logic [7:0]                    brightness,
`endif
   output logic [CHANNELS-1:0]           led_out,
   output logic                          busy,
   output logic                          done
);
   localparam int CW = $clog2(BIT_CYC);
   localparam int NW = N_LEDS > 1 ? $clog2(N_LEDS) : 1;
   localparam int LW = RESET_CYC > 1 ? $clog2(RESET_CYC) : 1;
   localparam logic [CW-1:0] BIT_END = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H = CW'(T1H_CYC);
   localparam logic [NW-1:0] LED_END = NW'(N_LEDS - 1);
   localparam logic [LW-1:0] LAT_END = LW'(RESET_CYC - 1);
   localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2;

   logic [1:0] st, st_n;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [4:0] bit_idx, bit_idx_n;
   logic [NW-1:0] led_idx, led_idx_n, load_idx;
   logic [LW-1:0] lat_cnt, lat_cnt_n;
   logic [CHANNELS-1:0][23:0] sr, sr_n;
   logic [CHANNELS-1:0] led_n;
   logic load, shift;

`ifdef LED_BRIGHTNESS_EN
   function automatic logic [7:0] scale(input logic [7:0] b);
      return 8'(({8'd0, b} * ({8'd0, brightness} + 16'd1)) >> 8);
   endfunction
`endif

   always_comb begin
      st_n = st;
      bit_cnt_n = bit_cnt;
      bit_idx_n = bit_idx;
      led_idx_n = led_idx;
      lat_cnt_n = lat_cnt;
      load = 1'b0;
      load_idx = '0;
      if (st == IDLE) begin
         if (start) begin
            st_n = SEND;
            load = 1'b1;
            bit_cnt_n = '0;
            bit_idx_n = '0;
            led_idx_n = '0;
         end
      end else if (st == SEND) begin
         bit_cnt_n = bit_cnt == BIT_END ? '0 : bit_cnt + 1'b1;
         if (bit_cnt == BIT_END) begin
            bit_idx_n = bit_idx == 5'd23 ? 5'd0 : bit_idx + 5'd1;
            if (bit_idx == 5'd23 && led_idx == LED_END) begin
               st_n = LATCH;
               lat_cnt_n = '0;
            end else if (bit_idx == 5'd23) begin
               led_idx_n = led_idx + 1'b1;
               load = 1'b1;
               load_idx = led_idx + 1'b1;
            end
         end
      end else begin
         lat_cnt_n = lat_cnt + 1'b1;
         if (lat_cnt == LAT_END) begin
            st_n = repeat_en ? SEND : IDLE;
            load = repeat_en;
            lat_cnt_n = '0;
            bit_cnt_n = '0;
            bit_idx_n = '0;
            led_idx_n = '0;
         end
      end
   end

   assign shift = st == SEND && bit_cnt == BIT_END;

   // led_out is registered from next-state values so the first bit appears right after acceptance
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [N_LEDS-1:0][23:0] pix;
      logic [23:0] px;
      assign pix = colors[c*N_LEDS*24 +: N_LEDS*24];
`ifdef LED_BRIGHTNESS_EN
      assign px = {scale(pix[load_idx][23:16]), scale(pix[load_idx][15:8]), scale(pix[load_idx][7:0])};
`else
      assign px = pix[load_idx];
`endif
      assign sr_n[c] = load ? px : shift ? {sr[c][22:0], 1'b0} : sr[c];
      assign led_n[c] = st_n == SEND && bit_cnt_n < (sr_n[c][23] ? T1H : T0H);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         led_idx <= '0;
         lat_cnt <= '0;
         sr <= '0;
         led_out <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         st <= st_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         led_idx <= led_idx_n;
         lat_cnt <= lat_cnt_n;
         sr <= sr_n;
         led_out <= led_n;
         busy <= st_n != IDLE;
         done <= st_n == LATCH && lat_cnt_n == LAT_END;
      end
   end
endmodule

// File: tb/tb_led_string_multi.sv
// tb_led_string_multi: frame-offset reference model compared every cycle, plus directed literal checks.
// Define LED_BRIGHTNESS_EN to also exercise the brightness scaler.
module tb_led_string_multi;
   localparam int CH = 2, NL = 2, T0 = 2, T1 = 4, BC = 6, RC = 10;
   localparam int W = CH * NL * 24;
   localparam int PIX_CYC = 24 * BC;
   localparam int SEND_CYC = NL * PIX_CYC;
   localparam int FRAME = SEND_CYC + RC;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, repeat_en = 1'b0;
   logic [W-1:0] colors = '0;
`ifdef LED_BRIGHTNESS_EN
   logic [7:0] brightness = 8'd255;
`endif
   logic [CH-1:0] led_out;
   logic busy, done;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   led_string_multi #(
      .CHANNELS(CH), .N_LEDS(NL), .T0H_CYC(T0), .T1H_CYC(T1), .BIT_CYC(BC), .RESET_CYC(RC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .colors(colors),
      .start(start),
      .repeat_en(repeat_en),
`ifdef LED_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .led_out(led_out),
      .busy(busy),
      .done(done)
   );

   // Reference model: position t within the current frame determines every output.
   logic [W-1:0] mwf = '0;
   bit act = 1'b0;
   int t = 0;
   logic [CH-1:0] e_led = '0;
   logic e_busy = 1'b0, e_done = 1'b0;

`ifdef LED_BRIGHTNESS_EN
   function automatic logic [7:0] sc(input logic [7:0] v);
      return 8'((int'(v) * (int'(brightness) + 1)) >> 8);
   endfunction
`endif

   function automatic logic [23:0] pix(input int c, input int k);
      logic [23:0] w;
      w = 24'(colors >> ((c * NL + k) * 24));
`ifdef LED_BRIGHTNESS_EN
      w = {sc(w[23:16]), sc(w[15:8]), sc(w[7:0])};
`endif
      return w;
   endfunction

   function automatic logic bitv(input int c, input int n);
      return 1'(mwf >> ((c * NL + n / 24) * 24 + 23 - n % 24));
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         act = 1'b0;
         t = 0;
      end else if (act) begin
         t++;
         if (t == FRAME) begin
            if (repeat_en) t = 0;
            else act = 1'b0;
         end
      end else if (start) begin
         act = 1'b1;
         t = 0;
      end
      if (act && t < SEND_CYC && t % PIX_CYC == 0)
         for (int c = 0; c < CH; c++) begin
            int off;
            off = (c * NL + t / PIX_CYC) * 24;
            mwf = (mwf & ~(W'(24'hFFFFFF) << off)) | (W'(pix(c, t / PIX_CYC)) << off);
         end
      e_busy = act;
      e_done = act && t == FRAME - 1;
      e_led = '0;
      if (act && t < SEND_CYC)
         for (int c = 0; c < CH; c++)
            if (t % BC < (bitv(c, t / BC) ? T1 : T0)) e_led = e_led | CH'(1 << c);
   end

   always @(negedge clk) begin
      checks++;
      if ({led_out, busy, done} !== {e_led, e_busy, e_done}) begin
         failures++;
         $display("FAIL model_cycle act=%0d t=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                  act, t, led_out, busy, done, e_led, e_busy, e_done);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic set_px(input int c, input int k, input logic [23:0] w);
      colors = (colors & ~(W'(24'hFFFFFF) << ((c * NL + k) * 24))) | (W'(w) << ((c * NL + k) * 24));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Samples the first byte of ch0 (bit value visible at phase 2) and counts its high cycles.
   task automatic grab(output logic [7:0] b0, output int hi0);
      b0 = '0;
      hi0 = 0;
      for (int i = 0; i < 8 * BC; i++) begin
         if (i % BC == 2) b0 = {b0[6:0], led_out[0]};
         hi0 += int'(led_out[0]);
         @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [47:0] d0, d1;
      logic [7:0] b0;
      int hi0, hi1, dt, n;
      cyc(3);
      rst = 1'b1;
      cyc(20);
      chk("idle_outputs", {led_out, busy, done}, 4'b0000);

      set_px(0, 0, 24'h00CEFF);
      set_px(0, 1, 24'h000000);
      set_px(1, 0, 24'hFFFFFF);
      set_px(1, 1, 24'h800001);
      kick();
      d0 = '0;
      d1 = '0;
      hi0 = 0;
      hi1 = 0;
      dt = -1;
      for (int i = 0; i <= FRAME; i++) begin
         if (i < SEND_CYC && i % BC == 2) begin
            d0 = {d0[46:0], led_out[0]};
            d1 = {d1[46:0], led_out[1]};
         end
         if (i < 8 * BC) hi0 += int'(led_out[0]);
         if (i < BC) hi1 += int'(led_out[1]);
         if (done && dt < 0) dt = i;
         if (i < FRAME) @(negedge clk);
      end
      chk("ch0_first8_highs", hi0, 16);
      chk("ch1_bit0_high", hi1, 4);
      chk("ch0_stream", d0, 48'h00CEFF000000);
      chk("ch1_stream", d1, 48'hFFFFFF800001);
      chk("done_latency", dt + 1, 298);
      chk("busy_after_frame", busy, 1'b0);

      start = 1'b1;
      @(negedge clk);
      wait_done(FRAME + 5, n);
      chk("hold_done", n, FRAME - 1);
      @(negedge clk);
      chk("hold_gap_busy", busy, 1'b0);
      @(negedge clk);
      chk("hold_restart", {led_out, busy}, 3'b111);
      start = 1'b0;
      cyc(40);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(100);
      start = 1'b1;
      cyc(3);
      start = 1'b0;
      wait_done(FRAME, n);
      chk("pulse_done", n, FRAME - 1 - 144);
      cyc(2);

      repeat_en = 1'b1;
      kick();
      cyc(290);
      set_px(0, 0, 24'hA5A5A5);
      set_px(1, 0, 24'h3C3C3C);
      wait_done(20, n);
      chk("rep_done", n, 7);
      @(negedge clk);
      chk("rep_restart", {led_out, busy}, 3'b111);
      grab(b0, hi0);
      chk("rep_new_data", b0, 8'hA5);
      repeat_en = 1'b0;
      wait_done(FRAME, n);
      chk("rep_last_done", n, FRAME - 1 - 48);
      cyc(2);

      kick();
      cyc(99);
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_outputs", {led_out, busy, done}, 4'b0000);
      rst = 1'b1;
      cyc(3);
      kick();
      wait_done(FRAME + 5, n);
      chk("fresh_frame_done", n, FRAME - 1);
      cyc(2);

`ifdef LED_BRIGHTNESS_EN
      set_px(0, 0, 24'hFF0000);
      brightness = 8'd127;
      kick();
      grab(b0, hi0);
      chk("bright127", b0, 8'h7F);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      brightness = 8'd0;
      kick();
      grab(b0, hi0);
      chk("bright0_highs", hi0, 16);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      brightness = 8'd255;
      cyc(2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
